// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, owner-state
// encoding and the sizing helper for the m0 burst counter.
package mem_if_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef logic [1:0] owner_t;

    localparam owner_t ST_IDLE = 2'd0;
    localparam owner_t ST_OWN0 = 2'd1;
    localparam owner_t ST_OWN1 = 2'd2;

    // Counter must hold 0..max_burst inclusive.
    function automatic int burst_cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rdata_return_reg.sv
// Per-port registered load-return path: captures memory read data on a
// granted load and raises rvalid for exactly the following cycle.
module rdata_return_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    // rdata is only overwritten by a new load so it holds after rvalid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= load;
            if (load) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: m0 has priority,
// m1 is forced in after MAX_BURST consecutive m0 grants while it waits.
module dmem_arbiter
    import mem_if_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int          CW        = burst_cnt_width(MAX_BURST);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic [CW-1:0] burst_cnt;
    owner_t        owner;

    // Grants are suppressed entirely while reset is high so no write can slip
    // through in the reset cycle.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                if (burst_cnt == BURST_MAX) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = m1_gnt ? m1_addr  : m0_addr;
        mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
        mem_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    end

    // burst_cnt only counts m0 grants that m1 actually had to wait through.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (m1_gnt || !m1_req) begin
            burst_cnt <= '0;
        end else if (m0_gnt && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= ST_IDLE;
        end else if (m0_gnt) begin
            owner <= ST_OWN0;
        end else if (m1_gnt) begin
            owner <= ST_OWN1;
        end else begin
            owner <= ST_IDLE;
        end
    end

    // Owner state is kept for debug visibility; it must never hold the spare code.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (owner inside {ST_IDLE, ST_OWN0, ST_OWN1});
            assert (!(m0_gnt && m1_gnt));
        end
    end

    rdata_return_reg #(.DW(DW)) u_ret0 (
        .clk       (clk),
        .reset     (reset),
        .load      (m0_gnt && !m0_we),
        .mem_rdata (mem_rdata),
        .rvalid    (m0_rvalid),
        .rdata     (m0_rdata)
    );

    rdata_return_reg #(.DW(DW)) u_ret1 (
        .clk       (clk),
        .reset     (reset),
        .load      (m1_gnt && !m1_we),
        .mem_rdata (mem_rdata),
        .rvalid    (m1_rvalid),
        .rdata     (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int WORDS     = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] env_mem [WORDS];
    logic [DW-1:0] ref_mem [WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    int            streak;
    logic          exp_g0, exp_g1;
    logic          exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd0, exp_rd1;
    logic          obs_g0, obs_g1;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for data_mem: combinational read, write at the clock edge.
    assign mem_rdata = env_mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic applyStimulus(input logic rst_i,
                                 input logic r0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic r1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        reset = rst_i;
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        #1;
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (!rst_i) begin
            if (r0 && r1) begin
                if (streak >= MAX_BURST) exp_g1 = 1'b1;
                else exp_g0 = 1'b1;
            end else if (r0) begin
                exp_g0 = 1'b1;
            end else if (r1) begin
                exp_g1 = 1'b1;
            end
        end
        obs_g0 = m0_gnt;
        obs_g1 = m1_gnt;
        checkOutput("m0_gnt", 32'(m0_gnt), 32'(exp_g0));
        checkOutput("m1_gnt", 32'(m1_gnt), 32'(exp_g1));
        checkOutput("mem_we", 32'(mem_we), 32'((exp_g0 && we0) || (exp_g1 && we1)));
        if (exp_g0 || exp_g1) begin
            checkOutput("mem_addr", mem_addr, exp_g0 ? a0 : a1);
            if ((exp_g0 && we0) || (exp_g1 && we1)) begin
                checkOutput("mem_wdata", mem_wdata, exp_g0 ? d0 : d1);
            end
        end
        checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
        checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
        checkOutput("m0_rdata", m0_rdata, exp_rd0);
        checkOutput("m1_rdata", m1_rdata, exp_rd1);

        if (rst_i) begin
            exp_rv0 = 1'b0; exp_rv1 = 1'b0;
            exp_rd0 = '0;   exp_rd1 = '0;
            streak  = 0;
        end else begin
            exp_rv0 = exp_g0 && !we0;
            exp_rv1 = exp_g1 && !we1;
            if (exp_rv0) exp_rd0 = ref_mem[a0[7:2]];
            if (exp_rv1) exp_rd1 = ref_mem[a1[7:2]];
            if (exp_g0 && we0) ref_mem[a0[7:2]] = d0;
            if (exp_g1 && we1) ref_mem[a1[7:2]] = d1;
            if (exp_g1 || !r1) streak = 0;
            else if (exp_g0) streak++;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [11:0]   seq3;
        logic          p0, p1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          rst_r;

        for (int i = 0; i < WORDS; i++) begin
            env_mem[i] = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        streak = 0;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        exp_rd0 = '0;   exp_rd1 = '0;

        // Reset with both ports requesting
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 32'h1, 1'b1, 1'b1, 32'h8, 32'h2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h1, 1'b1, 1'b0, 32'h8, 32'h2);
        idleCycle();
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);

        // m0 store then load of the same word
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        checkOutput("t2_store_we", 32'(obs_g0), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, '0, '0);
        idleCycle();
        checkOutput("t2_rvalid", 32'(m0_rvalid), 32'h1);
        checkOutput("t2_rdata", m0_rdata, 32'hDEAD_BEEF);
        checkOutput("t2_m1_rvalid", 32'(m1_rvalid), 32'h0);

        // Both requesting continuously: four m0 grants then one m1 grant
        seq3 = 12'h210;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'(i * 4), '0, 1'b1, 1'b0, 32'(i * 4 + 64), '0);
            checkOutput("t3_m1_gnt_seq", 32'(obs_g1), 32'(seq3[i]));
            checkOutput("t3_m0_gnt_seq", 32'(obs_g0), 32'(!seq3[i]));
        end
        idleCycle();

        // m1-only back-to-back loads
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'(i * 4), '0);
        end
        idleCycle();
        checkOutput("t4_word2", m1_rdata, 32'hA500_0002);
        idleCycle();

        // Conflict on 0x20: m0 load wins, m1 store follows, then m0 sees it
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, '0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        checkOutput("t5_m0_first", 32'(obs_g0), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        checkOutput("t5_old_data", m0_rdata, 32'hA500_0008);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, '0, 1'b0, 1'b0, '0, '0);
        idleCycle();
        checkOutput("t5_new_data", m0_rdata, 32'h1234_5678);

        // Reset right after an m0 load grant, with a store offered during reset
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b0, 1'b0, '0, '0);
        idleCycle();
        checkOutput("t6_rvalid_cleared", 32'(m0_rvalid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h30, '0, 1'b0, 1'b0, '0, '0);
        idleCycle();
        checkOutput("t6_mem_unchanged", m0_rdata, 32'hA500_000C);

        // Random traffic: each requester holds its request until granted
        p0 = 1'b0; p1 = 1'b0;
        w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin
                p0 = 1'b1;
                w0 = $urandom_range(0, 1) == 1;
                a0 = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                d0 = $urandom;
            end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin
                p1 = 1'b1;
                w1 = $urandom_range(0, 1) == 1;
                a1 = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                d1 = $urandom;
            end
            rst_r = ($urandom_range(0, 39) == 0);
            applyStimulus(rst_r, p0, w0, a0, d0, p1, w1, a1, d1);
            if (exp_g0) p0 = 1'b0;
            if (exp_g1) p1 = 1'b0;
        end
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port `data_mem` between two requesters.
  - m0: processor load/store port, high priority.
  - m1: host/DMA loader port, low priority with a starvation guard.
- Issues one access per cycle to memory.
- Registers read data and returns it with an `rvalid` pulse one cycle after grant.
- Sits in `top` between `processor`/loader and `data_mem`.

Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- MAX_BURST, 4, consecutive m0 grants allowed while m1 waits before m1 is forced in (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  m0 access request (held until granted)
- m0_we  in  1  m0 write enable (1=store, 0=load)
- m0_addr  in  AW  m0 byte address
- m0_wdata  in  DW  m0 store data
- m0_gnt  out  1  m0 granted this cycle (combinational)
- m0_rvalid  out  1  m0 load data valid (registered)
- m0_rdata  out  DW  m0 load data (registered)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1
- mem_we  out  1  to `data_mem` `we`
- mem_addr  out  AW  to `data_mem` `address`
- mem_wdata  out  DW  to `data_mem` `wd`
- mem_rdata  in  DW  from `data_mem` `rd` (combinational read)

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - owner state = IDLE, burst_cnt = 0.
  - m0_rvalid = m1_rvalid = 0; m0_rdata = m1_rdata = 0.
  - While reset is high, m0_gnt = m1_gnt = mem_we = 0 regardless of requests.
- Owner state records the previous cycle's grant: IDLE (none), OWN0, OWN1.
  - Next state = OWN0 if m0_gnt, OWN1 if m1_gnt, else IDLE.
  - State is observational only (debug, coverage); grant depends on requests and burst_cnt.
- Grant rule (combinational, same cycle as req):
  - Only m0_req → m0_gnt.
  - Only m1_req → m1_gnt.
  - Both requesting → m1_gnt if burst_cnt == MAX_BURST, else m0_gnt.
  - At most one grant per cycle. No grant without req.
- burst_cnt (registered, width clog2(MAX_BURST+1)):
  - Cleared when m1_gnt or m1_req == 0.
  - Otherwise +1 on each m0_gnt, saturating at MAX_BURST.
  - Result with both requesting continuously: exactly MAX_BURST m0 grants, then 1 m1 grant, repeating.
- Memory drive:
  - mem_addr/mem_wdata = granted port's addr/wdata.
  - With no grant, mem_addr/mem_wdata = m0 values (don't-care).
  - mem_we = granted port's we; 0 if no grant.
- Stores take effect at the clk edge ending the grant cycle. Nothing is returned; no rvalid.
- Loads:
  - In the grant cycle with we=0, mem_rdata is captured into that port's rdata at the clock edge.
  - That port's rvalid = 1 for exactly the following cycle.
  - Latency is grant + 1.
  - The other port's rdata holds its value.
  - rdata holds after rvalid falls until the next load for that port.
- Back-to-back loads on one port give a continuous rvalid high, with rdata updating each cycle.
- Read-after-write to the same address on consecutive grants returns the new data (the write completes at the edge).
- Address alignment: addr passes through unchanged; `data_mem` ignores addr[1:0]. No error signalling.
- Reset asserted mid-access:
  - The grant in the reset cycle is suppressed (no write).
  - A pending rvalid is cleared on the next edge.
  - A requester must re-present its request after reset.
- MAX_BURST=1 gives strict alternation while both request.

Decomposition:
- Shared package `mem_if_pkg`: AW/DW defaults, owner-state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), and a clog2 helper/localparam for burst_cnt width.
- One natural sub-module: `rdata_return_reg`. It is the per-port registered rdata/rvalid pair, instantiated twice.
- Grant logic and burst_cnt stay in the top.

Test Plan:
1. Reset with both req=1: m0_gnt=m1_gnt=mem_we=0 during reset; rvalid=0, rdata=0 after.
2. m0 store addr 0x10, data 0xDEADBEEF, then m0 load 0x10 → mem_we=1 in cycle 1; m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 3; m1_rvalid stays 0.
3. Both req held 12 cycles, MAX_BURST=4 → grant sequence 0,0,0,0,1,0,0,0,0,1,0,0; burst_cnt clears after each m1 grant.
4. m1-only loads at 0x0,0x4,0x8 back-to-back → m1_gnt each cycle; m1_rvalid high 3 consecutive cycles starting 1 cycle later, data matching memory words 0..2.
5. Same cycle m0 load 0x20 and m1 store 0x20 = 0x12345678 with burst_cnt<4 → m0 served (old data), m1 stalls; m1 written next cycle; a following m0 load returns 0x12345678.
6. Reset asserted in the cycle after an m0 load grant → m0_rvalid=0 after the reset edge; a store granted in the reset cycle leaves memory unchanged.
